// File: rtl/router_reg_gen.sv
// Router input register stage: captures the header, holds bytes in FIFO order while the
// destination FIFO is full, forwards bytes to the FIFO write path and verifies the trailing check byte.
module router_reg_gen #(
  parameter int DATA_W     = 8,
  parameter int HOLD_DEPTH = 4,
  parameter int CHK_MODE   = 0
) (
  input  logic                             clock,
  input  logic                             resetn,
  input  logic                             pkt_valid,
  input  logic [DATA_W-1:0]                data_in,
  input  logic                             fifo_full,
  input  logic                             detect_add,
  input  logic                             lfd_state,
  input  logic                             ld_state,
  input  logic                             laf_state,
  input  logic                             full_state,
  input  logic                             rst_int_reg,
  output logic [DATA_W-1:0]                dout,
  output logic                             dout_valid,
  output logic                             parity_done,
  output logic                             low_pkt_valid,
  output logic                             err,
  output logic [$clog2(HOLD_DEPTH+1)-1:0]  hold_count,
  output logic                             hold_ovf
);

  localparam int CW = $clog2(HOLD_DEPTH + 1);
  localparam int PW = (HOLD_DEPTH > 1) ? $clog2(HOLD_DEPTH) : 1;

  logic [DATA_W-1:0] hold_mem [HOLD_DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [DATA_W-1:0] header_reg;
  logic [DATA_W-1:0] internal_chk;
  logic [DATA_W-1:0] packet_chk;
  logic [DATA_W-1:0] chk_next;
  logic              chk_rcvd;
  logic              hold_empty;
  logic              hold_full;
  logic              ld_active;
  logic              header_cap;
  logic              direct_wr;
  logic              push;
  logic              pop;
  logic              drop;
  logic              accept;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(HOLD_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // full_state freezes the hold buffer; only ld_state may accept new bytes.
  always_comb begin
    hold_empty = (hold_count == '0);
    hold_full  = (hold_count == CW'(HOLD_DEPTH));
    ld_active  = ld_state && !full_state;
    header_cap = detect_add && pkt_valid;
    direct_wr  = ld_active && hold_empty && !fifo_full;
    push       = ld_active && !direct_wr && !hold_full;
    drop       = ld_active && !direct_wr && hold_full;
    pop        = (ld_state || laf_state) && !full_state && !fifo_full && !hold_empty;
    accept     = direct_wr || push;
    chk_next   = (CHK_MODE == 1) ? internal_chk + data_in : internal_chk ^ data_in;
  end

  always_ff @(posedge clock) begin
    if (push) hold_mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      if (lfd_state) begin
        dout       <= header_reg;
        dout_valid <= 1'b1;
      end else if (pop) begin
        dout       <= hold_mem[rd_ptr];
        dout_valid <= 1'b1;
      end else if (direct_wr) begin
        dout       <= data_in;
        dout_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      low_pkt_valid <= 1'b0;
    end else if (rst_int_reg) begin
      low_pkt_valid <= 1'b0;
    end else if (ld_state && !pkt_valid) begin
      low_pkt_valid <= 1'b1;
    end
  end

  // A new header restarts the packet: buffer, check state and sticky flags all clear.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      hold_count   <= '0;
      hold_ovf     <= 1'b0;
      header_reg   <= '0;
      internal_chk <= '0;
      packet_chk   <= '0;
      chk_rcvd     <= 1'b0;
      parity_done  <= 1'b0;
      err          <= 1'b0;
    end else if (header_cap) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      hold_count   <= '0;
      hold_ovf     <= 1'b0;
      header_reg   <= data_in;
      internal_chk <= data_in;
      packet_chk   <= '0;
      chk_rcvd     <= 1'b0;
      parity_done  <= 1'b0;
      err          <= 1'b0;
    end else begin
      if (accept && pkt_valid) internal_chk <= chk_next;
      if (accept && !pkt_valid) begin
        packet_chk <= data_in;
        chk_rcvd   <= 1'b1;
      end
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      hold_count <= hold_count + CW'(1);
      else if (pop && !push) hold_count <= hold_count - CW'(1);
      if (drop) hold_ovf <= 1'b1;
      // The check byte has left via dout once it is recorded and nothing remains held.
      if (chk_rcvd && hold_empty && !parity_done) begin
        parity_done <= 1'b1;
        err         <= (internal_chk != packet_chk);
      end
    end
  end

endmodule

// File: tb/tb_router_reg_gen.sv
// Testbench for router_reg_gen: directed and randomized packets on an XOR-check and a sum-check
// instance, compared against a queue-based model of the output stream, hold buffer and check rules.
module tb_router_reg_gen;
  localparam int DATA_W     = 8;
  localparam int HOLD_DEPTH = 4;
  localparam int CW         = $clog2(HOLD_DEPTH + 1);

  logic              clock = 1'b0;
  logic              resetn;
  logic              pkt_valid;
  logic [DATA_W-1:0] data_in;
  logic              fifo_full;
  logic              detect_add;
  logic              lfd_state;
  logic              ld_state;
  logic              laf_state;
  logic              full_state;
  logic              rst_int_reg;

  logic [DATA_W-1:0] dout, s_dout;
  logic              dout_valid, s_dout_valid;
  logic              parity_done, s_parity_done;
  logic              low_pkt_valid, s_low_pkt_valid;
  logic              err, s_err;
  logic [CW-1:0]     hold_count, s_hold_count;
  logic              hold_ovf, s_hold_ovf;

  int checks = 0;
  int errors = 0;

  logic [DATA_W:0]   m_hold [$];
  logic [DATA_W-1:0] m_out [$];
  logic [DATA_W-1:0] obs_q [$];
  logic [DATA_W-1:0] obs_s [$];
  logic [DATA_W-1:0] m_header, m_xor, m_sum, m_chk, m_dout;
  logic              m_dv, m_pd, m_err, m_err_sum, m_ovf, m_low, m_left;

  always #5 clock = ~clock;

  router_reg_gen #(.DATA_W(DATA_W), .HOLD_DEPTH(HOLD_DEPTH), .CHK_MODE(0)) dut (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .detect_add(detect_add), .lfd_state(lfd_state),
    .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
    .rst_int_reg(rst_int_reg), .dout(dout), .dout_valid(dout_valid),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid), .err(err),
    .hold_count(hold_count), .hold_ovf(hold_ovf)
  );

  router_reg_gen #(.DATA_W(DATA_W), .HOLD_DEPTH(HOLD_DEPTH), .CHK_MODE(1)) dut_sum (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .detect_add(detect_add), .lfd_state(lfd_state),
    .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
    .rst_int_reg(rst_int_reg), .dout(s_dout), .dout_valid(s_dout_valid),
    .parity_done(s_parity_done), .low_pkt_valid(s_low_pkt_valid), .err(s_err),
    .hold_count(s_hold_count), .hold_ovf(s_hold_ovf)
  );

  // Reference model: a packet is a byte stream; bytes leave in arrival order, header first.
  task automatic tick();
    int sz;
    bit ld_eff, mv_eff, direct, pop, push, drop;
    logic [DATA_W:0] ev;
    if (!resetn) begin
      m_hold.delete();
      {m_header, m_xor, m_sum, m_chk, m_dout} = '0;
      {m_dv, m_pd, m_err, m_err_sum, m_ovf, m_low, m_left} = '0;
    end else begin
      sz     = m_hold.size();
      ld_eff = ld_state && !full_state;
      mv_eff = (ld_state || laf_state) && !full_state;
      direct = ld_eff && sz == 0 && !fifo_full;
      pop    = mv_eff && !fifo_full && sz > 0;
      push   = ld_eff && !direct && sz < HOLD_DEPTH;
      drop   = ld_eff && !direct && sz >= HOLD_DEPTH;
      if (m_left && !m_pd) begin
        m_pd      = 1'b1;
        m_err     = (m_xor != m_chk);
        m_err_sum = (m_sum != m_chk);
      end
      m_dv = 1'b0;
      if (lfd_state) begin
        m_dout = m_header; m_dv = 1'b1;
      end else if (pop) begin
        ev = m_hold.pop_front();
        m_dout = ev[DATA_W-1:0]; m_dv = 1'b1;
        if (ev[DATA_W]) m_left = 1'b1;
      end else if (direct) begin
        m_dout = data_in; m_dv = 1'b1;
        if (!pkt_valid) m_left = 1'b1;
      end
      if (push) m_hold.push_back({!pkt_valid, data_in});
      if (direct || push) begin
        if (pkt_valid) begin
          m_xor = m_xor ^ data_in;
          m_sum = m_sum + data_in;
        end else begin
          m_chk = data_in;
        end
      end
      if (drop) m_ovf = 1'b1;
      if (m_dv) m_out.push_back(m_dout);
      if (rst_int_reg) m_low = 1'b0;
      else if (ld_state && !pkt_valid) m_low = 1'b1;
      if (detect_add && pkt_valid) begin
        m_header = data_in; m_xor = data_in; m_sum = data_in; m_chk = '0;
        {m_pd, m_err, m_err_sum, m_ovf, m_left} = '0;
        m_hold.delete();
      end
    end
    @(posedge clock);
    #1;
    if (dout_valid)   obs_q.push_back(dout);
    if (s_dout_valid) obs_s.push_back(s_dout);
  endtask

  task automatic set_idle();
    {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg, fifo_full, pkt_valid} = '0;
    data_in = DATA_W'($urandom);
  endtask

  task automatic clear_streams();
    obs_q.delete(); obs_s.delete(); m_out.delete();
  endtask

  task automatic start_packet(input logic [DATA_W-1:0] hdr);
    set_idle(); detect_add = 1'b1; pkt_valid = 1'b1; data_in = hdr; tick();
    set_idle(); lfd_state = 1'b1; pkt_valid = 1'b1; tick();
  endtask

  task automatic send_byte(input logic [DATA_W-1:0] b, input logic valid, input logic full);
    set_idle(); ld_state = 1'b1; pkt_valid = valid; data_in = b; fifo_full = full; tick();
  endtask

  task automatic drain();
    for (int i = 0; i < HOLD_DEPTH + 2 && m_hold.size() > 0; i++) begin
      set_idle(); laf_state = 1'b1; tick();
    end
  endtask

  task automatic end_packet();
    set_idle(); rst_int_reg = 1'b1; tick();
    set_idle(); tick();
  endtask

  function automatic bit stream_ok();
    if (obs_q.size() != m_out.size() || obs_s.size() != m_out.size()) return 1'b0;
    foreach (m_out[i]) if (obs_q[i] !== m_out[i] || obs_s[i] !== m_out[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic test_reset();
    resetn = 1'b0; set_idle(); ld_state = 1'b1; pkt_valid = 1'b1; tick();
    set_idle(); lfd_state = 1'b1; tick();
    checks++; if (dout !== '0 || dout_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_dout got %h/%b exp 00/0", dout, dout_valid); end
    checks++; if (parity_done !== 1'b0 || err !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags got pd=%b err=%b exp 0/0", parity_done, err); end
    checks++; if (low_pkt_valid !== 1'b0 || hold_ovf !== 1'b0) begin errors++; $display("[TB] FAIL reset_low_ovf got %b/%b exp 0/0", low_pkt_valid, hold_ovf); end
    checks++; if (hold_count !== '0 || s_hold_count !== '0) begin errors++; $display("[TB] FAIL reset_count got %0d/%0d exp 0", hold_count, s_hold_count); end
    resetn = 1'b1;
  endtask

  task automatic test_xor_no_stall();
    clear_streams();
    start_packet(8'h05);
    send_byte(8'h11, 1'b1, 1'b0);
    send_byte(8'h22, 1'b1, 1'b0);
    send_byte(8'h36, 1'b0, 1'b0);
    checks++; if (low_pkt_valid !== 1'b1) begin errors++; $display("[TB] FAIL ns_low_set got %b exp 1", low_pkt_valid); end
    end_packet();
    checks++; if (obs_q.size() != 4 || obs_q[0] !== 8'h05 || obs_q[1] !== 8'h11 || obs_q[2] !== 8'h22 || obs_q[3] !== 8'h36) begin
      errors++; $display("[TB] FAIL ns_stream got %0d bytes exp 05 11 22 36", obs_q.size()); end
    checks++; if (parity_done !== 1'b1 || err !== 1'b0) begin errors++; $display("[TB] FAIL ns_check got pd=%b err=%b exp 1/0", parity_done, err); end
    checks++; if (s_err !== m_err_sum) begin errors++; $display("[TB] FAIL ns_sum_err got %b exp %b", s_err, m_err_sum); end
    checks++; if (low_pkt_valid !== 1'b0) begin errors++; $display("[TB] FAIL ns_low_clr got %b exp 0", low_pkt_valid); end
    checks++; if (dout !== 8'h36 || dout_valid !== 1'b0) begin errors++; $display("[TB] FAIL ns_dout_hold got %h/%b exp 36/0", dout, dout_valid); end
  endtask

  task automatic test_xor_mismatch();
    clear_streams();
    start_packet(8'h05);
    send_byte(8'h11, 1'b1, 1'b0);
    send_byte(8'h22, 1'b1, 1'b0);
    send_byte(8'h37, 1'b0, 1'b0);
    checks++; if (dout !== 8'h37 || dout_valid !== 1'b1 || parity_done !== 1'b0) begin
      errors++; $display("[TB] FAIL mm_chk_out got %h/%b pd=%b exp 37/1 pd=0", dout, dout_valid, parity_done); end
    set_idle(); tick();
    checks++; if (parity_done !== 1'b1 || err !== 1'b1) begin errors++; $display("[TB] FAIL mm_err got pd=%b err=%b exp 1/1", parity_done, err); end
    set_idle(); rst_int_reg = 1'b1; tick();
    checks++; if (parity_done !== 1'b1 || err !== 1'b1) begin errors++; $display("[TB] FAIL mm_err_keep got pd=%b err=%b exp 1/1", parity_done, err); end
    set_idle(); detect_add = 1'b1; pkt_valid = 1'b1; data_in = 8'h09; tick();
    checks++; if (parity_done !== 1'b0 || err !== 1'b0) begin errors++; $display("[TB] FAIL mm_err_clr got pd=%b err=%b exp 0/0", parity_done, err); end
  endtask

  task automatic test_stall();
    clear_streams();
    start_packet(8'h05);
    send_byte(8'h11, 1'b1, 1'b0);
    send_byte(8'h22, 1'b1, 1'b1);
    send_byte(8'h33, 1'b1, 1'b1);
    checks++; if (hold_count !== CW'(2) || dout !== 8'h11) begin errors++; $display("[TB] FAIL st_held got cnt=%0d dout=%h exp 2/11", hold_count, dout); end
    set_idle(); full_state = 1'b1; fifo_full = 1'b1; tick();
    checks++; if (hold_count !== CW'(2) || dout_valid !== 1'b0) begin errors++; $display("[TB] FAIL st_fullstate got cnt=%0d dv=%b exp 2/0", hold_count, dout_valid); end
    send_byte(8'h05, 1'b0, 1'b0);
    checks++; if (dout !== 8'h22 || hold_count !== CW'(2)) begin errors++; $display("[TB] FAIL st_pushpop got %h cnt=%0d exp 22/2", dout, hold_count); end
    set_idle(); laf_state = 1'b1; tick();
    checks++; if (dout !== 8'h33 || hold_count !== CW'(1) || parity_done !== 1'b0) begin
      errors++; $display("[TB] FAIL st_pop33 got %h cnt=%0d pd=%b exp 33/1/0", dout, hold_count, parity_done); end
    set_idle(); laf_state = 1'b1; tick();
    checks++; if (dout !== 8'h05 || hold_count !== CW'(0) || parity_done !== 1'b0) begin
      errors++; $display("[TB] FAIL st_popchk got %h cnt=%0d pd=%b exp 05/0/0", dout, hold_count, parity_done); end
    set_idle(); tick();
    checks++; if (parity_done !== 1'b1 || err !== 1'b0) begin errors++; $display("[TB] FAIL st_check got pd=%b err=%b exp 1/0", parity_done, err); end
    checks++; if (!stream_ok()) begin errors++; $display("[TB] FAIL st_stream got %0d bytes exp %0d", obs_q.size(), m_out.size()); end
  endtask

  task automatic test_overflow();
    clear_streams();
    start_packet(8'h05);
    for (int i = 1; i <= 5; i++) send_byte(DATA_W'(i * 16), 1'b1, 1'b1);
    checks++; if (hold_count !== CW'(4) || hold_ovf !== 1'b1) begin errors++; $display("[TB] FAIL ov_full got cnt=%0d ovf=%b exp 4/1", hold_count, hold_ovf); end
    drain();
    send_byte(8'h45, 1'b0, 1'b0);
    end_packet();
    checks++; if (obs_q.size() != 6 || obs_q[4] !== 8'h40 || obs_q[5] !== 8'h45) begin
      errors++; $display("[TB] FAIL ov_stream got %0d bytes exp 05 10 20 30 40 45", obs_q.size()); end
    checks++; if (parity_done !== 1'b1 || err !== 1'b0 || hold_ovf !== 1'b1) begin
      errors++; $display("[TB] FAIL ov_check got pd=%b err=%b ovf=%b exp 1/0/1", parity_done, err, hold_ovf); end
    checks++; if (s_err !== 1'b1) begin errors++; $display("[TB] FAIL ov_sum_err got %b exp 1", s_err); end
  endtask

  task automatic test_sum_mode();
    clear_streams();
    start_packet(8'h05);
    send_byte(8'h11, 1'b1, 1'b0);
    send_byte(8'h22, 1'b1, 1'b0);
    send_byte(8'h38, 1'b0, 1'b0);
    end_packet();
    checks++; if (s_err !== 1'b0 || s_parity_done !== 1'b1 || err !== 1'b1) begin
      errors++; $display("[TB] FAIL sum_basic got s_err=%b s_pd=%b err=%b exp 0/1/1", s_err, s_parity_done, err); end
    start_packet(8'h05);
    send_byte(8'hF0, 1'b1, 1'b0);
    send_byte(8'h20, 1'b1, 1'b0);
    send_byte(8'h15, 1'b0, 1'b0);
    end_packet();
    checks++; if (s_err !== 1'b0 || s_parity_done !== 1'b1) begin errors++; $display("[TB] FAIL sum_wrap got s_err=%b s_pd=%b exp 0/1", s_err, s_parity_done); end
  endtask

  task automatic test_reset_mid_packet();
    logic [DATA_W-1:0] b;
    start_packet(8'h5A);
    send_byte(8'h01, 1'b1, 1'b1);
    send_byte(8'h02, 1'b1, 1'b1);
    checks++; if (hold_count !== CW'(2)) begin errors++; $display("[TB] FAIL rm_held got %0d exp 2", hold_count); end
    resetn = 1'b0; set_idle(); ld_state = 1'b1; pkt_valid = 1'b0; tick();
    resetn = 1'b1;
    checks++; if (hold_count !== '0 || dout !== '0 || dout_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL rm_clear got cnt=%0d dout=%h dv=%b exp 0/00/0", hold_count, dout, dout_valid); end
    checks++; if ({parity_done, err, low_pkt_valid, hold_ovf} !== 4'b0) begin
      errors++; $display("[TB] FAIL rm_flags got %b exp 0000", {parity_done, err, low_pkt_valid, hold_ovf}); end
    clear_streams();
    start_packet(DATA_W'($urandom));
    for (int i = 0; i < 3; i++) begin
      b = DATA_W'($urandom);
      send_byte(b, 1'b1, 1'b0);
    end
    send_byte(m_xor, 1'b0, 1'b0);
    end_packet();
    checks++; if (parity_done !== 1'b1 || err !== 1'b0) begin errors++; $display("[TB] FAIL rm_clean got pd=%b err=%b exp 1/0", parity_done, err); end
    checks++; if (!stream_ok()) begin errors++; $display("[TB] FAIL rm_stream got %0d bytes exp %0d", obs_q.size(), m_out.size()); end
  endtask

  task automatic test_random();
    logic [DATA_W-1:0] chk;
    int n;
    for (int p = 0; p < 25; p++) begin
      clear_streams();
      start_packet(DATA_W'($urandom));
      n = $urandom_range(1, 7);
      for (int i = 0; i < n; i++) send_byte(DATA_W'($urandom), 1'b1, $urandom_range(0, 2) == 0);
      if (m_hold.size() == HOLD_DEPTH) drain();
      chk = ($urandom_range(0, 1) == 1) ? m_sum : m_xor;
      if ($urandom_range(0, 3) == 0) chk = chk ^ 8'h01;
      send_byte(chk, 1'b0, $urandom_range(0, 2) == 0);
      drain();
      end_packet();
      checks++; if (!stream_ok()) begin errors++; $display("[TB] FAIL rnd_stream pkt %0d got %0d bytes exp %0d", p, obs_q.size(), m_out.size()); end
      checks++; if (parity_done !== m_pd || s_parity_done !== m_pd) begin
        errors++; $display("[TB] FAIL rnd_pd pkt %0d got %b/%b exp %b", p, parity_done, s_parity_done, m_pd); end
      checks++; if (err !== m_err || s_err !== m_err_sum) begin
        errors++; $display("[TB] FAIL rnd_err pkt %0d got %b/%b exp %b/%b", p, err, s_err, m_err, m_err_sum); end
      checks++; if (hold_ovf !== m_ovf || s_hold_ovf !== m_ovf) begin
        errors++; $display("[TB] FAIL rnd_ovf pkt %0d got %b/%b exp %b", p, hold_ovf, s_hold_ovf, m_ovf); end
      checks++; if (hold_count !== CW'(m_hold.size()) || s_hold_count !== CW'(m_hold.size())) begin
        errors++; $display("[TB] FAIL rnd_count pkt %0d got %0d/%0d exp %0d", p, hold_count, s_hold_count, m_hold.size()); end
      checks++; if (low_pkt_valid !== m_low || s_low_pkt_valid !== m_low) begin
        errors++; $display("[TB] FAIL rnd_low pkt %0d got %b/%b exp %b", p, low_pkt_valid, s_low_pkt_valid, m_low); end
    end
  endtask

  initial begin
    resetn = 1'b0;
    set_idle();
    test_reset();
    test_xor_no_stall();
    test_xor_mismatch();
    test_stall();
    test_overflow();
    test_sum_mode();
    test_reset_mid_packet();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/router_reg_gen.md
Name: router_reg_gen

Overview:
- Next-generation router input register stage. It captures the header, buffers payload bytes that arrive while the destination FIFO is full, and forwards bytes to the FIFO write path.
- It computes a running packet check, compares it against the trailing check byte, and reports the result.
- Sits between the router input pins and the FIFO write mux. It is sequenced by the router FSM strobes (detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg).
- Changes from the previous stage: parametrised data width, a multi-entry hold buffer in place of the single full-state byte, a selectable check algorithm, and an explicit output-valid strobe.

Parameters:
- DATA_W, 8, width of data_in, dout and the check bytes.
- HOLD_DEPTH, 4, number of entries in the full-state hold buffer (>=1). HOLD_DEPTH=1 gives single-byte hold behaviour.
- CHK_MODE, 0, check algorithm. 0 = bitwise XOR. 1 = additive sum mod 2^DATA_W.

Ports:
- clock  in  1  rising-edge clock
- resetn  in  1  reset
- pkt_valid  in  1  high for header and payload bytes; low while the check byte is on data_in
- data_in  in  DATA_W  input byte
- fifo_full  in  1  selected destination FIFO is full
- detect_add  in  1  FSM strobe: header on data_in
- lfd_state  in  1  FSM: load first data (header) to FIFO
- ld_state  in  1  FSM: load data
- laf_state  in  1  FSM: load after full
- full_state  in  1  FSM: FIFO-full wait state
- rst_int_reg  in  1  FSM: end-of-packet internal clear
- dout  out  DATA_W  byte to FIFO
- dout_valid  out  1  dout updated this cycle (FIFO write enable)
- parity_done  out  1  check byte captured and all packet bytes forwarded
- low_pkt_valid  out  1  pkt_valid has fallen during ld_state
- err  out  1  check mismatch
- hold_count  out  $clog2(HOLD_DEPTH+1)  current hold-buffer occupancy
- hold_ovf  out  1  sticky: a byte was dropped because the hold buffer was full

Behaviour:
- Reset: resetn, synchronous, active-low; clock clock. On reset, every output, the hold buffer pointers, the header register, both check registers and the check-received flag go to 0.
- All outputs are registered. dout and dout_valid appear one cycle after the qualifying input cycle.
- Header capture: when detect_add && pkt_valid, header_reg <= data_in and internal_chk <= data_in. The same cycle clears packet_chk, parity_done, err, hold_ovf, the check-received flag and the hold buffer.
- lfd_state: dout <= header_reg and dout_valid <= 1.
- Accept rule in ld_state:
  - Hold empty && !fifo_full: direct write, dout <= data_in, dout_valid <= 1.
  - Otherwise, if the hold buffer is not full, push data_in. Bytes are never forwarded ahead of held bytes.
  - Hold buffer full: the byte is dropped and hold_ovf is set. Dropped bytes are excluded from the check.
- Pop rule: when (ld_state || laf_state) && !fifo_full && hold not empty, pop the oldest entry to dout with dout_valid <= 1.
- Push and pop in the same cycle leave hold_count unchanged; FIFO order is preserved.
- full_state: no push and no pop. data_in is ignored because the FSM stalls the source.
- dout holds its value whenever dout_valid is 0.
- Check accumulation: every accepted byte (direct or pushed) with pkt_valid=1 updates internal_chk. CHK_MODE 0 uses internal_chk ^ data_in; CHK_MODE 1 uses internal_chk + data_in, truncated to DATA_W.
- Check byte: an accepted byte in ld_state with pkt_valid=0 sets packet_chk <= data_in and the check-received flag. It is still forwarded to the FIFO like any other byte.
- low_pkt_valid: set on ld_state && !pkt_valid. Cleared on rst_int_reg or reset. rst_int_reg has priority.
- parity_done: rises the cycle after the check-received flag is set and the hold buffer is empty, i.e. once the check byte has left via dout. It stays high until detect_add or reset.
- err: err <= (internal_chk != packet_chk), evaluated on the parity_done rising edge. Held until detect_add or reset.
- rst_int_reg does not clear err or parity_done.
- Reset mid-packet wins over every strobe and discards held bytes. Simultaneous detect_add and ld_state cannot occur under the FSM and is not required.

Test Plan:
- XOR, no stall: header 0x05, payload 0x11,0x22, check 0x36 -> dout sequence 05,11,22,36 on four dout_valid pulses; parity_done=1; err=0.
- XOR mismatch: same packet with check 0x37 -> parity_done=1 one cycle after 0x37 is output; err=1; err clears on the next detect_add.
- Stall: fifo_full high while 0x22 and 0x33 arrive -> hold_count=2; after fifo_full drops, the bytes pop in order 22 then 33, one per cycle; parity_done only after hold_count=0.
- Overflow (HOLD_DEPTH=4): five bytes arrive with fifo_full high -> hold_count=4, hold_ovf=1; the fifth byte is never output and is excluded from the check.
- CHK_MODE=1: header 0x05, payload 0x11,0x22, check 0x38 -> err=0. Payload 0xF0,0x20, header 0x05, check 0x15 (wraps) -> err=0.
- Reset mid-packet: resetn low after two held bytes -> the next cycle shows hold_count=0, dout=0, all flags 0; a following clean packet passes with err=0.
